// File: rtl/regfile_param_if.sv
// Register-file bus: control, write port and NRD flattened read ports.
// The master drives requests. The slave (regfile_param) returns read data and status.
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
);
  logic                     clr;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NRD*ADDR_W-1:0]    raddr;
  logic [NRD*DATA_W-1:0]    rdata;
  logic                     ready;
  logic [ADDR_W-1:0]        busy_idx;
  logic                     wr_drop;

  modport master (
    output clr, we, waddr, wdata, raddr,
    input  rdata, ready, busy_idx, wr_drop
  );

  modport slave (
    input  clr, we, waddr, wdata, raddr,
    output rdata, ready, busy_idx, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with one write port, NRD async read ports, and a clear sweep.
// REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_param_rdport #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  input  logic                         en_i,
  input  logic                         fwd_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o
);
  always_comb begin
    rdata_o = '0;
    if (en_i) begin
      if (fwd_i && (raddr_i == waddr_i)) rdata_o = wdata_i;
      else                               rdata_o = mem_i[raddr_i];
    end
  end
endmodule

module regfile_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
) (
  input logic            clk,
  input logic            rst,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;
  logic                          drop_q, drop_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q;

  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_waddr;
  logic [DATA_W-1:0]             mem_wdata;
  logic                          rd_en;
  logic                          fwd;
  logic [NRD-1:0][DATA_W-1:0]    rd_w;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.wdata;
    unique case (state_q)
      S_CLEAR: begin
        drop_d = bus.we;
        if (bus.clr) begin
          idx_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = idx_q;
          mem_wdata = '0;
          idx_d     = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = S_READY;
            idx_d   = '0;
          end
        end
      end
      S_READY: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          drop_d  = bus.we;
        end else begin
          mem_we = bus.we;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Storage has no reset; only the sweep zeroes it, and reads are masked until then.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_en = (state_q == S_READY);

`ifdef REGFILE_BYPASS_EN
  assign fwd = rd_en && bus.we && !bus.clr;
`else
  assign fwd = 1'b0;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_param_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rd (
      .mem_i   (mem_q),
      .raddr_i (bus.raddr[k*ADDR_W +: ADDR_W]),
      .en_i    (rd_en),
      .fwd_i   (fwd),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
      .rdata_o (rd_w[k])
    );
  end

  assign bus.rdata    = rd_w;
  assign bus.ready    = rd_en;
  assign bus.busy_idx = idx_q;
  assign bus.wr_drop  = drop_q;
endmodule

// File: tb/tb_regfile_param.sv
// Randomised plus directed bench for regfile_param, checked by a scoreboard against a
// behavioural model of the register file.
module tb_regfile_param;
  localparam int DW = 16, AW = 3, NRD = 2, DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus ();
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic                  rdy;
    logic [AW-1:0]         idx;
    logic                  drop;
    logic [NRD-1:0][DW-1:0] rd;
  } exp_t;

  exp_t q[$];
  int compared = 0, mismatched = 0;

  // Model: a word array, a "clearing" flag with sweep position, and the pending drop flag.
  bit          clearing_m = 1'b1;
  int          idx_m = 0;
  bit          drop_m = 1'b0;
  logic [DW-1:0] mem_m [DEPTH];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready", 64'(bus.ready), 64'(e.rdy));
      chk("busy_idx", 64'(bus.busy_idx), 64'(e.idx));
      chk("wr_drop", 64'(bus.wr_drop), 64'(e.drop));
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rdata%0d", k), 64'(bus.rdata[k*DW +: DW]), 64'(e.rd[k]));
    end
  end

  task automatic cyc(input logic r, input logic c, input logic w, input int wa,
                     input logic [DW-1:0] wd, input int ra0, input int ra1);
    exp_t e;
    int   ra;
    rst        = r;
    bus.clr    = c;
    bus.we     = w;
    bus.waddr  = AW'(wa);
    bus.wdata  = wd;
    bus.raddr  = {AW'(ra1), AW'(ra0)};
    e.rdy  = !clearing_m;
    e.idx  = AW'(idx_m);
    e.drop = drop_m;
    for (int k = 0; k < NRD; k++) begin
      ra = (k == 0) ? ra0 : ra1;
      e.rd[k] = clearing_m ? '0 : mem_m[ra];
`ifdef REGFILE_BYPASS_EN
      if (!clearing_m && w && !c && ra == wa) e.rd[k] = wd;
`endif
    end
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      clearing_m = 1'b1; idx_m = 0; drop_m = 1'b0;
    end else begin
      drop_m = w && (clearing_m || c);
      if (clearing_m) begin
        if (c) idx_m = 0;
        else begin
          mem_m[idx_m] = '0;
          if (idx_m == DEPTH-1) begin clearing_m = 1'b0; idx_m = 0; end
          else idx_m++;
        end
      end else if (c) begin
        clearing_m = 1'b1; idx_m = 0;
      end else if (w) begin
        mem_m[wa] = wd;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input int ra0, input int ra1);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0, ra0, ra1);
  endtask

  initial begin
    rst = 1'b1; bus.clr = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    @(posedge clk); #1;
    // Reset sweep, then read back every word.
    cyc(1'b1, 1'b0, 1'b0, 0, '0, 3, 7);
    idle(8, 3, 7);
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, 1'b0, 0, '0, a, DEPTH-1-a);
    // Basic writes and the same-cycle read of the write address.
    cyc(1'b0, 1'b0, 1'b1, 3, 16'hA5A5, 3, 7);
    cyc(1'b0, 1'b0, 1'b1, 7, 16'h1234, 3, 7);
    idle(1, 3, 7);
    cyc(1'b0, 1'b0, 1'b1, 3, 16'hBEEF, 3, 7);
    idle(1, 3, 3);
    // Clear together with a write.
    cyc(1'b0, 1'b0, 1'b1, 2, 16'h5555, 2, 3);
    cyc(1'b0, 1'b1, 1'b1, 2, 16'hFFFF, 2, 2);
    idle(9, 2, 3);
    // Write during a sweep.
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 5, 5);
    idle(2, 5, 5);
    cyc(1'b0, 1'b0, 1'b1, 5, 16'h00FF, 5, 5);
    idle(7, 5, 5);
    // Restart by clr, then by rst, at sweep index 4.
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 0, 1);
    idle(4, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 0, 1);
    idle(9, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 0, 1);
    idle(4, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 0, '0, 0, 1);
    idle(9, 0, 1);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, c, w;
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 39) == 0);
      w = !r && ($urandom_range(0, 1) == 1);
      cyc(r, c, w, $urandom_range(0, DEPTH-1), DW'($urandom),
          $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
    end
    idle(1, 0, 0);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file with a hardware clear sequencer, for the multicycle RISC datapath and its wider-word variants. Holds `2**ADDR_W` words of `DATA_W` bits, with one synchronous write port and `NRD` asynchronous read ports. After reset, or on request, a built-in sweep zeroes every entry one word per cycle, then raises `ready`. Optional write-to-read forwarding is compiled in by macro.

## Interface
- `DATA_W`, default 16: word width in bits; legal range 1..64.
- `ADDR_W`, default 3: address width; `DEPTH = 2**ADDR_W`; legal range 1..8.
- `NRD`, default 2: number of read ports; legal range 1..4.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `clr`  in  1: start a clear sweep; sampled on the rising edge.
- `we`  in  1: write enable.
- `waddr`  in  ADDR_W: write address.
- `wdata`  in  DATA_W: write data.
- `raddr`  in  NRD*ADDR_W: read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `rdata`  out  NRD*DATA_W: read data; port k uses bits `[k*DATA_W +: DATA_W]`; combinational.
- `ready`  out  1: 1 when the file is usable; 0 during a clear sweep.
- `busy_idx`  out  ADDR_W: current sweep index; 0 when `ready` is 1.
- `wr_drop`  out  1: registered pulse; 1 for one cycle after a `we` was ignored.

## Operation
- Two states, CLEAR and READY.
- `rst` has priority over everything else:
  - state goes to CLEAR; `busy_idx` = 0; `ready` = 0; `wr_drop` = 0.
  - Storage is not reset directly. Only the sweep zeroes it.
- CLEAR state:
  - Each edge with `rst` = 0 and `clr` = 0 writes 0 to `mem[busy_idx]`, then increments `busy_idx`.
  - The edge that clears index `DEPTH-1` moves the state to READY, sets `busy_idx` = 0 and sets `ready` = 1.
  - `clr` = 1 in CLEAR restarts the sweep: `busy_idx` = 0 and nothing is written on that edge.
- READY state:
  - `we` = 1 writes `wdata` to `mem[waddr]` on the edge.
  - `clr` = 1 moves the state to CLEAR with `busy_idx` = 0, and `ready` drops on that edge.
  - If `clr` and `we` are both 1 in the same cycle, the write is dropped and `wr_drop` = 1 on the next cycle.
- Any `we` = 1 sampled while the state is CLEAR is ignored, and `wr_drop` = 1 on the next cycle.
- Read ports:
  - `rdata[k]` = `mem[raddr[k]]`, combinational from the stored array.
  - All ports are independent. Any number of ports may read the same address.
  - While `ready` = 0, every `rdata` port is forced to 0. Stale or uncleared contents are never visible.
- No address is out of range, because depth is an exact power of two.

## Timing
- Reset values: `ready` = 0, `busy_idx` = 0, `wr_drop` = 0, `rdata` = 0 (forced).
- Reset-to-ready latency:
  - `rst` is deasserted before edge E1.
  - Edges E1..E_DEPTH clear indices 0..DEPTH-1.
  - `ready` = 1 after edge E_DEPTH, which is 8 cycles for `ADDR_W` = 3.
- A `clr` sampled at edge E gives the same latency: `ready` = 1 after edge E+DEPTH.
- Write latency is one edge. Without the bypass, a read of `waddr` in the write cycle returns the old word, and the new word appears after the edge.
- Reset mid-sweep restarts at index 0 with no partial state kept.
- `rst` together with `clr` or `we` behaves as `rst` alone, and `wr_drop` stays 0.

## Configuration
- `REGFILE_BYPASS_EN`, when defined:
  - In READY, if `we` = 1 and `raddr[k]` == `waddr`, then `rdata[k]` = `wdata` combinationally in the same cycle.
  - This applies per port, independently.
  - There is no forwarding while `ready` = 0 or when the write is dropped because `clr` = 1.
- When undefined, reads always return stored contents. There is no `wdata` path to `rdata`.

## Test plan
All scenarios use `DATA_W` = 16, `ADDR_W` = 3, `NRD` = 2.
- Reset sweep:
  - Stimulus: assert `rst` for 1 cycle, then release it.
  - Response: `busy_idx` steps 0..7 and `rdata` = 0 throughout; `ready` = 1 exactly 8 edges after release; then every address reads 0x0000.
- Basic write/read:
  - Stimulus: write 0xA5A5 to address 3 and 0x1234 to address 7; read port 0 = address 3, port 1 = address 7.
  - Response: 0xA5A5 and 0x1234, visible from the edge after each write.
- Same-cycle read of the write address:
  - Stimulus: address 3 holds 0xA5A5; write 0xBEEF to address 3 while port 0 reads address 3.
  - Response without the macro: 0xA5A5 in that cycle, 0xBEEF after the edge.
  - Response with `REGFILE_BYPASS_EN`: 0xBEEF in the same cycle.
- Clear with a write in the same cycle:
  - Stimulus: in READY, assert `clr` together with `we` (address 2, 0xFFFF).
  - Response: `wr_drop` = 1 for exactly one cycle; `ready` = 0 for 8 cycles; afterwards address 2 reads 0x0000.
- Write during a sweep:
  - Stimulus: during CLEAR, assert `we` to address 5 with 0x00FF.
  - Response: the write is ignored and `wr_drop` pulses; after `ready`, address 5 reads 0x0000.
- Restart mid-sweep:
  - Stimulus: assert `clr` while `busy_idx` = 4, or assert `rst` while `busy_idx` = 4.
  - Response: `busy_idx` returns to 0; `ready` rises 8 edges after the restart edge.
